packet_inject_mux: RTL

Parametrised, synthesizable multi-source packet injector front end for the many-core NoC. It accepts up to N_CH independent credit-based flit streams, such as the management and application injectors, and buffers each in its own FIFO. It forwards whole packets, never interleaved, onto one credit-based router local port using packet-granular round-robin arbitration. It also produces an aggregated end-of-application flag.

---
 rtl/packet_inject_mux.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/packet_inject_mux.sv
// rtl/packet_inject_mux.sv - multi-source packet injector with per-channel FIFOs
// and packet-granular round-robin onto one credit-based router port.
module packet_inject_mux #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int BUF_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH-1:0]           src_rx_i,
  output logic [N_CH-1:0]           src_credit_o,
  input  logic [N_CH*FLIT_SIZE-1:0] src_data_i,
  input  logic [N_CH-1:0]           src_eoa_i,
  output logic                      tx_o,
  input  logic                      credit_i,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic [N_CH-1:0]           grant_o,
  output logic                      eoa_o
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t                          state;
  logic [CH_W-1:0]                 g;
  logic [CH_W-1:0]                 rr_ptr;
  logic [CH_W-1:0]                 sel;
  logic                            found;
  int                              cand;
  logic [FLIT_SIZE-1:0]            cnt;
  logic [N_CH-1:0]                 eoa_seen;
  logic [N_CH-1:0]                 empty;
  logic [N_CH-1:0]                 full;
  logic [N_CH-1:0]                 wr_en;
  logic [N_CH-1:0]                 pop;
  logic [N_CH-1:0][FLIT_SIZE-1:0]  head;
  logic [FLIT_SIZE-1:0]            cur_flit;
  logic                            xfer;

  for (genvar c = 0; c < N_CH; c++) begin : g_fifo
    logic [FLIT_SIZE-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;

    // Writes while full are dropped here, so a misbehaving source cannot corrupt the FIFO.
    assign empty[c] = (count == '0);
    assign full[c]  = (count == (PTR_W+1)'(BUF_DEPTH));
    assign wr_en[c] = src_rx_i[c] && !full[c];
    assign pop[c]   = xfer && (g == CH_W'(c));
    assign head[c]  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
      if (wr_en[c]) mem[wr_ptr] <= src_data_i[c*FLIT_SIZE +: FLIT_SIZE];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en[c]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[c])   rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en[c], pop[c]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign cur_flit     = head[g];
  assign tx_o         = (state != IDLE) && !empty[g];
  assign data_o       = tx_o ? cur_flit : '0;
  assign xfer         = tx_o && credit_i;
  assign src_credit_o = ~full;
  assign eoa_o        = (&eoa_seen) && (&empty) && (state == IDLE);

  // Round-robin search starts one past the last owner, wrapping at N_CH.
  always_comb begin
    found = 1'b0;
    sel   = rr_ptr;
    cand  = 0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!found && !empty[CH_W'(cand)]) begin
        found = 1'b1;
        sel   = CH_W'(cand);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) eoa_seen <= '0;
    else       eoa_seen <= eoa_seen | src_eoa_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      g       <= '0;
      rr_ptr  <= CH_W'(N_CH - 1);
      cnt     <= '0;
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          g       <= sel;
          rr_ptr  <= sel;
          grant_o <= N_CH'(1) << sel;
          state   <= HEADER;
        end
        HEADER: if (xfer) state <= SIZE;
        SIZE: if (xfer) begin
          cnt <= cur_flit;
          if (cur_flit != '0) begin
            state <= PAYLOAD;
          end else begin
            state   <= IDLE;
            grant_o <= '0;
          end
        end
        PAYLOAD: if (xfer) begin
          cnt <= cnt - 1'b1;
          if (cnt == FLIT_SIZE'(1)) begin
            state   <= IDLE;
            grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
